// File: rtl/dm_unload.sv
// dm_unload: reads a block of words from a fixed-latency data memory and
// streams them out on a valid/ready interface through a small skid FIFO.
// Reads are credit-limited, so in-flight reads plus queued words never
// exceed FIFO_DEPTH and the FIFO cannot overflow.
// Optional feature macro: DM_UNLOAD_STALL_CNT_EN adds a saturating 16-bit
// stall_cnt output (cycles with m_tvalid & !m_tready).
//
//   state | meaning
//   IDLE  | waiting for start; start is ignored in every other state
//   ISSUE | issuing memory reads while FIFO credit allows
//   DRAIN | all reads issued; waiting for the tlast beat to be accepted
//   FIN   | one-cycle done pulse, then back to IDLE
module dm_unload #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast
`ifdef DM_UNLOAD_STALL_CNT_EN
  , output logic [15:0]     stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W:0]    left_q, left_d;
  logic [ADDR_W-1:0]  next_addr_q, next_addr_d;
  logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
  logic [RD_LAT-1:0]  vpipe_q, vpipe_d;
  logic [RD_LAT-1:0]  lpipe_q, lpipe_d;
  logic [DATA_W:0]    fifo_q [FIFO_DEPTH];
  logic [DATA_W:0]    fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               start_ok;
  logic               issue;
  logic               issue_last;
  logic               push;
  logic               pop;
  logic               credit_ok;
  logic [15:0]        inflight;
  logic [DATA_W:0]    head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign start_ok   = (state_q == IDLE) && start;
  assign issue      = (state_q == ISSUE) && credit_ok;
  assign issue_last = issue && (left_q == (ADDR_W+1)'(1));
  assign push       = vpipe_q[RD_LAT-1];
  assign head       = fifo_q[rd_ptr_q];
  assign m_tvalid   = (cnt_q != '0);
  assign m_tdata    = m_tvalid ? head[DATA_W-1:0] : '0;
  assign m_tlast    = m_tvalid & head[DATA_W];
  assign pop        = m_tvalid & m_tready;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign mem_rden   = issue;
  // Show the address being read; otherwise hold the last issued address.
  assign mem_raddr  = issue ? next_addr_q : last_addr_q;

  // Credit: every word read but not yet handed out must fit in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + 16'(vpipe_q[i]);
    end
    credit_ok = (inflight + 16'(cnt_q)) < 16'(FIFO_DEPTH);
  end

  // Next-state, read address and remaining-read counter.
  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    next_addr_d = next_addr_q;
    last_addr_d = last_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          next_addr_d = base_addr;
          left_d      = len;
          state_d     = (len == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          next_addr_d = next_addr_q + ADDR_W'(1);
          last_addr_d = next_addr_q;
          left_d      = left_q - (ADDR_W+1)'(1);
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_tlast) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read-valid and last-tag shift registers matching memory latency.
  always_comb begin
    vpipe_d    = vpipe_q;
    lpipe_d    = lpipe_q;
    vpipe_d[0] = issue;
    lpipe_d[0] = issue_last;
    for (int i = 1; i < RD_LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
      lpipe_d[i] = lpipe_q[i-1];
    end
  end

  // Skid FIFO: push returning data, pop on handshake.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {lpipe_q[RD_LAT-1], mem_rdata};
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      left_q      <= '0;
      next_addr_q <= '0;
      last_addr_q <= '0;
      vpipe_q     <= '0;
      lpipe_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      next_addr_q <= next_addr_d;
      last_addr_q <= last_addr_d;
      vpipe_q     <= vpipe_d;
      lpipe_q     <= lpipe_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // FIFO storage needs no reset; outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

`ifdef DM_UNLOAD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled valid cycles, restarted per transfer.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_ok)
      stall_cnt_d = '0;
    else if (m_tvalid && !m_tready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dm_unload.sv
// Self-checking bench for dm_unload: table of transfers plus hand-written
// reset/abort sequence. Memory model has 2-cycle read latency.
module tb_dm_unload;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  len = '0;
  logic        busy, done, mem_rden;
  logic [7:0]  mem_raddr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
`ifdef DM_UNLOAD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  dm_unload dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_rden(mem_rden), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast)
`ifdef DM_UNLOAD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] rd_s1;

  always @(posedge clk) begin
    rd_s1     <= mem[mem_raddr];
    mem_rdata <= rd_s1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] base;
    logic [8:0] len;
    bit         toggle;
    int         exp_first;
    int         exp_done;
    int         exp_stalls;
  } vec_t;

  vec_t vecs[6];

  task automatic run_xfer(input logic [7:0] b, input logic [8:0] l, input bit tog,
                          input int exp_first, input int exp_done, input int exp_stalls);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int j = 0, issued = 0, popped = 0, stalls = 0, first = -1, done_cyc = -1;
    logic [7:0] a;
    for (int k = 0; k < 600 && done_cyc < 0; k++) begin
      @(negedge clk);
      start     = (k == 0);
      base_addr = b;
      len       = l;
      m_tready  = tog ? pat[k % 4] : 1'b1;
      #1;
      if (k == 0) check("idle_busy_at_start", {63'd0, busy}, 64'd0);
      if (mem_rden) begin
        a = b + 8'(issued);
        check("mem_raddr", {56'd0, mem_raddr}, {56'd0, a});
        check("credit_limit", {63'd0, (issued - popped) < 4}, 64'd1);
        issued++;
      end
      if (m_tvalid) begin
        if (first < 0) first = k;
        a = b + 8'(j);
        check("m_tdata", {32'd0, m_tdata}, {32'd0, mem[a]});
        check("m_tlast", {63'd0, m_tlast}, {63'd0, j == int'(l) - 1});
        if (m_tready) begin
          j++;
          popped++;
        end else begin
          stalls++;
        end
      end
      if (done) begin
        done_cyc = k;
`ifdef DM_UNLOAD_STALL_CNT_EN
        check("stall_cnt", {48'd0, stall_cnt}, 64'(exp_stalls));
`endif
      end
    end
    start = 1'b0;
    check("first_valid_cycle", 64'(first), 64'(exp_first));
    check("done_cycle", 64'(done_cyc), 64'(exp_done));
    check("beat_count", 64'(j), 64'(l));
    check("read_count", 64'(issued), 64'(l));
    check("stall_cycles", 64'(stalls), 64'(exp_stalls));
  endtask

  initial begin
    int beats, issued, bad;
    logic [7:0] a;

    for (int i = 0; i < 256; i++) mem[i] = {8'h5A, 8'(i), 16'(i * 37)};
    mem[8'h10] = 32'hAAAA_0001;
    mem[8'h11] = 32'hBBBB_0002;
    mem[8'h12] = 32'hCCCC_0003;
    mem[8'h13] = 32'hDDDD_0004;

    //        base   len     tog first done stalls
    vecs[0] = '{8'h10, 9'd4,   0, 4, 8,   0};
    vecs[1] = '{8'hFE, 9'd4,   0, 4, 8,   0};
    vecs[2] = '{8'h00, 9'd8,   1, 4, 20,  8};
    vecs[3] = '{8'h20, 9'd0,   0, -1, 1,  0};
    vecs[4] = '{8'hFF, 9'd1,   0, 4, 5,   0};
    vecs[5] = '{8'h80, 9'd256, 0, 4, 260, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_busy",  {63'd0, busy},      64'd0);
    check("rst_done",  {63'd0, done},      64'd0);
    check("rst_rden",  {63'd0, mem_rden},  64'd0);
    check("rst_raddr", {56'd0, mem_raddr}, 64'd0);
    check("rst_valid", {63'd0, m_tvalid},  64'd0);
    check("rst_tlast", {63'd0, m_tlast},   64'd0);
    check("rst_tdata", {32'd0, m_tdata},   64'd0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++)
      run_xfer(vecs[v].base, vecs[v].len, vecs[v].toggle,
               vecs[v].exp_first, vecs[v].exp_done, vecs[v].exp_stalls);

    // Start while busy is ignored; reset after three beats aborts cleanly.
    beats  = 0;
    issued = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      start     = (k == 0) || (k == 2);
      base_addr = (k == 2) ? 8'h00 : 8'h40;
      len       = (k == 2) ? 9'd1 : 9'd16;
      m_tready  = 1'b1;
      #1;
      if (mem_rden) begin
        a = 8'h40 + 8'(issued);
        check("abort_raddr", {56'd0, mem_raddr}, {56'd0, a});
        issued++;
      end
      if (m_tvalid && m_tready) begin
        a = 8'h40 + 8'(beats);
        check("abort_tdata", {32'd0, m_tdata}, {32'd0, mem[a]});
        beats++;
      end
    end
    check("abort_beats_before_rst", 64'(beats), 64'd3);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy",  {63'd0, busy},      64'd0);
    check("abort_done",  {63'd0, done},      64'd0);
    check("abort_rden",  {63'd0, mem_rden},  64'd0);
    check("abort_raddr0", {56'd0, mem_raddr}, 64'd0);
    check("abort_valid", {63'd0, m_tvalid},  64'd0);
    check("abort_tlast", {63'd0, m_tlast},   64'd0);
    check("abort_tdata0", {32'd0, m_tdata},  64'd0);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (m_tvalid || done || busy || mem_rden) bad++;
    end
    check("abort_quiet_after_rst", 64'(bad), 64'd0);

    run_xfer(8'h00, 9'd2, 1'b0, 4, 6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_unload.md
DM_UNLOAD -- requirements
Module: dm_unload

Interface
REQ-001 Parameter DATA_W, default 32, width of one data-memory word (2 x DATA_WIDTH).
REQ-002 Parameter ADDR_W, default 8, data-memory address width (256 entries).
REQ-003 Parameter RD_LAT, default 2, data-memory read latency in cycles (HIGH_PERFORMANCE BRAM).
REQ-004 Parameter FIFO_DEPTH, default 4, output skid FIFO depth; SHALL be >= RD_LAT+2.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle request to unload a block.
REQ-008 base_addr  in  ADDR_W  first word address, sampled on accepted start.
REQ-009 len  in  ADDR_W+1  word count 0..256, sampled on accepted start.
REQ-010 busy  out  1  transfer in progress.
REQ-011 done  out  1  one-cycle pulse at transfer completion.
REQ-012 mem_rden  out  1  data-memory read enable.
REQ-013 mem_raddr  out  ADDR_W  data-memory read address.
REQ-014 mem_rdata  in  DATA_W  data-memory read data, valid RD_LAT cycles after mem_rden.
REQ-015 m_tdata  out  DATA_W  stream data.
REQ-016 m_tvalid  out  1  stream valid.
REQ-017 m_tready  in  1  stream ready from consumer.
REQ-018 m_tlast  out  1  marks final word of the transfer.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, DRAIN, FIN; start SHALL be accepted only in IDLE and ignored otherwise.
REQ-020 IDLE->ISSUE on start with len!=0; IDLE->FIN on start with len==0 (no reads, no beats).
REQ-021 In ISSUE, mem_rden SHALL assert only when (reads in flight + FIFO occupancy) < FIFO_DEPTH; the FIFO SHALL never overflow.
REQ-022 mem_raddr SHALL start at base_addr and increment by 1 per issued read, wrapping 255->0 without error.
REQ-023 ISSUE->DRAIN in the cycle after the len-th read issues; DRAIN->FIN on handshake (m_tvalid & m_tready) of the word carrying m_tlast; FIN->IDLE unconditionally after one cycle.
REQ-024 mem_rdata SHALL be pushed into the FIFO exactly RD_LAT cycles after its mem_rden cycle via a RD_LAT-deep valid shift register.
REQ-025 m_tvalid SHALL equal FIFO non-empty; m_tdata/m_tlast SHALL be stable while m_tvalid & !m_tready; pop only on handshake.
REQ-026 m_tlast SHALL be high only on the len-th word of the transfer.
REQ-027 With m_tready held high, first m_tvalid SHALL occur 4 cycles after the start cycle, then one word per cycle with no bubbles.
REQ-028 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-029 busy SHALL be high in ISSUE, DRAIN and FIN; done SHALL be high only in FIN.
REQ-030 mem_rden SHALL be 0 outside ISSUE; mem_raddr SHALL hold its last value when mem_rden is 0.

Reset
REQ-031 rst SHALL force IDLE, flush FIFO and in-flight valid pipe, and clear counters.
REQ-032 Reset values: busy=0, done=0, mem_rden=0, mem_raddr=0, m_tvalid=0, m_tlast=0, m_tdata=0.
REQ-033 rst asserted mid-transfer SHALL abort with no further beats and no done pulse; data returning after reset SHALL be discarded.

Configuration
REQ-034 Macro DM_UNLOAD_STALL_CNT_EN defined: add output stall_cnt [15:0], counts cycles with m_tvalid & !m_tready, saturates at 16'hFFFF, cleared on rst and on accepted start.
REQ-035 Macro undefined: stall_cnt port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-036 Preload mem[0x10..0x13]=A,B,C,D; start base=0x10 len=4, tready=1 -> beats A,B,C,D on consecutive cycles, first at start+4, tlast on D, done one cycle later.
REQ-037 base=0xFE len=4 -> mem_raddr sequence FE,FF,00,01; data matches those addresses.
REQ-038 len=8, tready toggled 1,0,0,1 repeating -> all 8 words in order, no loss/duplication, mem_rden never issues with 4 words in flight+queued; stall_cnt=number of stalled valid cycles (macro on).
REQ-039 len=0 -> no mem_rden, no m_tvalid, busy high 1 cycle, done pulse 1 cycle after start.
REQ-040 start during busy ignored; rst asserted after 3 beats of len=16 -> all outputs at reset values next cycle, no done, next start (base=0, len=2) completes normally.
